// File: rtl/exc_seq.sv
// Exception/interrupt entry and ERET sequencer for the 5-stage MIPS pipeline.
// Holds the pipeline while the M-stage bus drains, then commits to CP0, flushes and redirects.
module exc_seq #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned NUM_HW       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic [31:0]       m_pc,
    input  logic              m_bd,
    input  logic              m_exc,
    input  logic [4:0]        m_exccode,
    input  logic              m_eret,
    input  logic [NUM_HW-1:0] hwint,
    input  logic              sr_ie,
    input  logic              sr_exl,
    input  logic [NUM_HW-1:0] sr_im,
    input  logic [31:0]       epc,
    input  logic              bus_busy,
    output logic              stall,
    output logic              flush,
    output logic              exc_commit,
    output logic [4:0]        exc_code,
    output logic [31:0]       exc_epc,
    output logic              exc_bd,
    output logic [NUM_HW-1:0] exc_ip,
    output logic              eret_commit,
    output logic              redirect,
    output logic [31:0]       redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT,
        ERET
    } state_t;

    state_t state, state_nx;

    logic [NUM_HW-1:0] ip_masked;
    logic              int_req;
    logic              exc_req;
    logic              take;
    logic              eret_req;
    logic [31:0]       pc_word;
    logic [31:0]       take_epc;

    logic [4:0]        lat_code;
    logic [31:0]       lat_epc;
    logic              lat_bd;
    logic [NUM_HW-1:0] lat_ip;
    logic [31:0]       lat_ret;

    assign ip_masked = hwint & sr_im;
    assign int_req   = (|ip_masked) & sr_ie & ~sr_exl;
    assign exc_req   = m_exc & ~sr_exl;
    assign take      = m_valid & (int_req | exc_req);
    assign eret_req  = m_valid & m_eret & ~take;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign pc_word   = {m_pc[31:2], 2'b00};
    assign take_epc  = m_bd ? (pc_word - 32'd4) : pc_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_code <= '0;
            lat_epc  <= '0;
            lat_bd   <= 1'b0;
            lat_ip   <= '0;
            lat_ret  <= '0;
        end else if (state == IDLE) begin
            if (take) begin
                lat_code <= int_req ? 5'd0 : m_exccode;
                lat_epc  <= take_epc;
                lat_bd   <= m_bd;
                lat_ip   <= ip_masked;
            end else if (eret_req) begin
                lat_ret  <= {epc[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        state_nx    = state;
        stall       = 1'b0;
        flush       = 1'b0;
        exc_commit  = 1'b0;
        exc_code    = '0;
        exc_epc     = '0;
        exc_bd      = 1'b0;
        exc_ip      = '0;
        eret_commit = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (state)
            IDLE: begin
                // Gated so a held reset never shows a stall from live inputs.
                stall = take & ~reset;
                if (take) begin
                    state_nx = bus_busy ? DRAIN : COMMIT;
                end else if (eret_req) begin
                    state_nx = ERET;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (!bus_busy) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                stall      = 1'b1;
                flush      = 1'b1;
                exc_commit = 1'b1;
                exc_code   = lat_code;
                exc_epc    = lat_epc;
                exc_bd     = lat_bd;
                exc_ip     = lat_ip;
                state_nx   = REDIRECT;
            end
            REDIRECT: begin
                stall       = 1'b1;
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = HANDLER_ADDR;
                state_nx    = IDLE;
            end
            ERET: begin
                stall       = 1'b1;
                flush       = 1'b1;
                eret_commit = 1'b1;
                redirect    = 1'b1;
                redirect_pc = lat_ret;
                state_nx    = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
